mips_bus_arb: RTL and testbench

MIPS_BUS_ARB -- requirements
Module: mips_bus_arb

---
 rtl/mips_bus_arb.sv | 135 +++++++++++++
 tb/tb_mips_bus_arb.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_bus_arb.sv
// mips_bus_arb: shares one memory port between the instruction-fetch
// requester and the data requester. Only one memory transaction is
// outstanding at a time. A completed transfer returns a one-cycle ack to
// its owner, along with the registered read word.
//
// Optional feature: define MIPS_BUS_ARB_FAIR_EN to arbitrate ties
// round-robin using a last-grant flag. When it is undefined, data always
// wins a tie.
module mips_bus_arb (
  input  logic        clock,
  input  logic        reset,
  input  logic        ireq,
  input  logic [31:0] ia,
  output logic        iack,
  output logic [31:0] idata,
  input  logic        dreq,
  input  logic [31:0] da,
  input  logic [3:0]  dwe,
  input  logic [31:0] dwd,
  output logic        dack,
  output logic [31:0] drd,
  output logic [31:0] ma,
  output logic [3:0]  mwe,
  output logic [31:0] mdo,
  output logic        mreq,
  input  logic        mrdy,
  input  logic [31:0] mdi,
  output logic        stall
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IBUS = 2'd1,
    DBUS = 2'd2
  } state_t;

  state_t state;
  logic   i_elig;
  logic   d_elig;
  logic   grant_i;
  logic   grant_d;

`ifdef MIPS_BUS_ARB_FAIR_EN
  // 1 = data was granted most recently, 0 = fetch was.
  logic   last_d;
`endif

  // A requester that is seeing its ack this cycle still has its old request
  // held, so it must not be granted a second time.
  // Priority is resolved on the raw requests. The grant is then taken only
  // if the winner is eligible. As a result, a held data request that is in
  // its ack cycle delays the next grant by one cycle and does not hand the
  // bus to fetch.
  always_comb begin
    i_elig  = ireq & ~iack;
    d_elig  = dreq & ~dack;
    grant_i = 1'b0;
    grant_d = 1'b0;
`ifdef MIPS_BUS_ARB_FAIR_EN
    if (ireq && dreq) begin
      grant_i = last_d & i_elig;
      grant_d = ~last_d & d_elig;
    end else begin
      grant_i = i_elig;
      grant_d = d_elig;
    end
`else
    grant_d = d_elig;
    grant_i = i_elig & ~dreq;
`endif
  end

  // Arbitration FSM. It latches the memory command on a grant, and
  // registers the read word and the ack on completion.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      ma    <= 32'h0;
      mwe   <= 4'h0;
      mdo   <= 32'h0;
      idata <= 32'h0;
      drd   <= 32'h0;
      iack  <= 1'b0;
      dack  <= 1'b0;
`ifdef MIPS_BUS_ARB_FAIR_EN
      last_d <= 1'b1;
`endif
    end else begin
      iack <= 1'b0;
      dack <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_d) begin
            state <= DBUS;
            ma    <= da;
            mwe   <= dwe;
            mdo   <= dwd;
`ifdef MIPS_BUS_ARB_FAIR_EN
            last_d <= 1'b1;
`endif
          end else if (grant_i) begin
            state <= IBUS;
            ma    <= ia;
            mwe   <= 4'h0;
            mdo   <= 32'h0;
`ifdef MIPS_BUS_ARB_FAIR_EN
            last_d <= 1'b0;
`endif
          end
        end
        IBUS: begin
          if (mrdy) begin
            state <= IDLE;
            idata <= mdi;
            iack  <= 1'b1;
          end
        end
        DBUS: begin
          // Writes also capture mdi and ack, so the handshake is uniform.
          if (mrdy) begin
            state <= IDLE;
            drd   <= mdi;
            dack  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The memory request is decoded directly from the state register.
  assign mreq  = (state != IDLE);
  assign stall = (ireq & ~iack) | (dreq & ~dack);

endmodule

// File: tb/tb_mips_bus_arb.sv
// Directed testbench for mips_bus_arb: reset, single fetch, write with
// wait states, read, tie arbitration and reset mid-transaction.
module tb_mips_bus_arb;

  logic        clock = 1'b0;
  logic        reset;
  logic        ireq;
  logic [31:0] ia;
  logic        iack;
  logic [31:0] idata;
  logic        dreq;
  logic [31:0] da;
  logic [3:0]  dwe;
  logic [31:0] dwd;
  logic        dack;
  logic [31:0] drd;
  logic [31:0] ma;
  logic [3:0]  mwe;
  logic [31:0] mdo;
  logic        mreq;
  logic        mrdy;
  logic [31:0] mdi;
  logic        stall;

  int compared   = 0;
  int mismatched = 0;

  mips_bus_arb dut (
    .clock (clock),
    .reset (reset),
    .ireq  (ireq),
    .ia    (ia),
    .iack  (iack),
    .idata (idata),
    .dreq  (dreq),
    .da    (da),
    .dwe   (dwe),
    .dwd   (dwd),
    .dack  (dack),
    .drd   (drd),
    .ma    (ma),
    .mwe   (mwe),
    .mdo   (mdo),
    .mreq  (mreq),
    .mrdy  (mrdy),
    .mdi   (mdi),
    .stall (stall)
  );

  always #5 clock = ~clock;

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    ireq = 1'b0; ia = 32'h0; dreq = 1'b0; da = 32'h0;
    dwe = 4'h0; dwd = 32'h0; mrdy = 1'b0; mdi = 32'h0;
    #2;
    compared++;
    if (mreq !== 1'b0) begin mismatched++; $display("FAIL reset_mreq got=%b exp=0", mreq); end
    compared++;
    if ({iack, dack} !== 2'b00) begin mismatched++; $display("FAIL reset_acks got=%b exp=00", {iack, dack}); end
    compared++;
    if ({ma, mwe, mdo} !== 68'h0) begin mismatched++; $display("FAIL reset_cmd got=%h exp=0", {ma, mwe, mdo}); end
    compared++;
    if ({idata, drd} !== 64'h0) begin mismatched++; $display("FAIL reset_rdata got=%h exp=0", {idata, drd}); end
    $display("reset: mreq=%b iack=%b dack=%b ma=%h", mreq, iack, dack, ma);
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic test_single_fetch();
    tick();
    ireq = 1'b1; ia = 32'h0000_0100; mrdy = 1'b1; mdi = 32'h8C01_0004;
    tick();
    compared++;
    if (mreq !== 1'b1) begin mismatched++; $display("FAIL fetch_mreq got=%b exp=1", mreq); end
    compared++;
    if (ma !== 32'h100) begin mismatched++; $display("FAIL fetch_ma got=%h exp=00000100", ma); end
    compared++;
    if (mwe !== 4'h0) begin mismatched++; $display("FAIL fetch_mwe got=%h exp=0", mwe); end
    compared++;
    if (stall !== 1'b1) begin mismatched++; $display("FAIL fetch_stall1 got=%b exp=1", stall); end
    tick();
    compared++;
    if (iack !== 1'b1) begin mismatched++; $display("FAIL fetch_iack got=%b exp=1", iack); end
    compared++;
    if (idata !== 32'h8C01_0004) begin mismatched++; $display("FAIL fetch_idata got=%h exp=8c010004", idata); end
    compared++;
    if (dack !== 1'b0) begin mismatched++; $display("FAIL fetch_dack got=%b exp=0", dack); end
    compared++;
    if (stall !== 1'b0) begin mismatched++; $display("FAIL fetch_stall2 got=%b exp=0", stall); end
    tick();
    compared++;
    if ({mreq, iack} !== 2'b00) begin mismatched++; $display("FAIL fetch_no_regrant got=%b exp=00", {mreq, iack}); end
    $display("single_fetch: ia=%h idata=%h", ia, idata);
    ireq = 1'b0;
    tick();
  endtask

  task automatic test_write_wait();
    dreq = 1'b1; da = 32'h2000; dwe = 4'b0011; dwd = 32'h0000_BEEF;
    mrdy = 1'b0; mdi = 32'hCAFE_F00D;
    for (int k = 1; k <= 4; k++) begin
      tick();
      compared++;
      if ({mreq, ma, mwe, mdo} !== {1'b1, 32'h2000, 4'b0011, 32'h0000_BEEF}) begin
        mismatched++;
        $display("FAIL write_hold_c%0d got mreq=%b ma=%h mwe=%h mdo=%h exp 1/00002000/3/0000beef", k, mreq, ma, mwe, mdo);
      end
      compared++;
      if (dack !== 1'b0) begin mismatched++; $display("FAIL write_early_dack_c%0d got=%b exp=0", k, dack); end
      if (k == 4) mrdy = 1'b1;
    end
    tick();
    compared++;
    if (dack !== 1'b1) begin mismatched++; $display("FAIL write_dack got=%b exp=1", dack); end
    compared++;
    if (drd !== 32'hCAFE_F00D) begin mismatched++; $display("FAIL write_drd got=%h exp=cafef00d", drd); end
    compared++;
    if ({mreq, iack} !== 2'b00) begin mismatched++; $display("FAIL write_idle got=%b exp=00", {mreq, iack}); end
    tick();
    compared++;
    if ({mreq, dack} !== 2'b00) begin mismatched++; $display("FAIL write_one_dack got=%b exp=00", {mreq, dack}); end
    $display("write_wait: da=%h dwe=%b dwd=%h drd=%h", da, dwe, dwd, drd);
    dreq = 1'b0; dwe = 4'h0;
    tick();
  endtask

  task automatic test_read();
    dreq = 1'b1; da = 32'h0000_0044; dwe = 4'h0; dwd = 32'h0; mrdy = 1'b1; mdi = 32'h1122_3344;
    tick();
    compared++;
    if ({mreq, ma, mwe} !== {1'b1, 32'h44, 4'h0}) begin
      mismatched++;
      $display("FAIL read_cmd got mreq=%b ma=%h mwe=%h exp 1/00000044/0", mreq, ma, mwe);
    end
    tick();
    compared++;
    if ({dack, drd} !== {1'b1, 32'h1122_3344}) begin
      mismatched++;
      $display("FAIL read_dack got dack=%b drd=%h exp 1/11223344", dack, drd);
    end
    $display("read: da=%h drd=%h", da, drd);
    dreq = 1'b0;
    tick();
  endtask

  task automatic test_tie();
    logic [3:0] exp_d;
    int grants;
    int acks;
    logic prev_mreq;
    logic owner_d;
`ifdef MIPS_BUS_ARB_FAIR_EN
    exp_d = 4'b1010;
`else
    exp_d = 4'b1111;
`endif
    grants = 0; acks = 0; prev_mreq = 1'b0; owner_d = 1'b0;
    ireq = 1'b1; ia = 32'h40; dreq = 1'b1; da = 32'h80; dwe = 4'h0;
    mrdy = 1'b1; mdi = 32'hA5A5_A5A5;
    for (int c = 0; c < 40 && acks < 4; c++) begin
      tick();
      compared++;
      if (stall !== 1'b1) begin mismatched++; $display("FAIL tie_stall c%0d got=%b exp=1", c, stall); end
      if (iack && dack) begin
        compared++; mismatched++;
        $display("FAIL tie_both_acks c%0d got=11 exp=not both", c);
      end
      if (mreq && !prev_mreq) begin
        owner_d = (ma == 32'h80);
        compared++;
        if (grants < 4 && owner_d !== exp_d[grants]) begin
          mismatched++;
          $display("FAIL tie_grant%0d got=%s exp=%s", grants, owner_d ? "D" : "I", exp_d[grants] ? "D" : "I");
        end
        $display("tie: grant%0d to %s", grants, owner_d ? "D" : "I");
        grants++;
      end
      if (iack || dack) begin
        compared++;
        if (dack !== owner_d) begin
          mismatched++;
          $display("FAIL tie_ack%0d got dack=%b iack=%b exp owner=%s", acks, dack, iack, owner_d ? "D" : "I");
        end
        acks++;
      end
      prev_mreq = mreq;
    end
    compared++;
    if (acks != 4 || grants != 4) begin
      mismatched++;
      $display("FAIL tie_count got grants=%0d acks=%0d exp 4/4", grants, acks);
    end
    ireq = 1'b0; dreq = 1'b0;
    tick(); tick();
  endtask

  task automatic test_reset_mid();
    dreq = 1'b1; da = 32'h3000; dwe = 4'h0; mrdy = 1'b0; mdi = 32'h0;
    tick();
    compared++;
    if (mreq !== 1'b1) begin mismatched++; $display("FAIL rmid_dbus got=%b exp=1", mreq); end
    #2 reset = 1'b0;
    #1;
    compared++;
    if ({mreq, dack, ma} !== {1'b0, 1'b0, 32'h0}) begin
      mismatched++;
      $display("FAIL rmid_async got mreq=%b dack=%b ma=%h exp 0/0/0", mreq, dack, ma);
    end
    dreq = 1'b0;
    #1 reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      compared++;
      if ({mreq, dack} !== 2'b00) begin mismatched++; $display("FAIL rmid_quiet_c%0d got=%b exp=00", k, {mreq, dack}); end
    end
    ireq = 1'b1; ia = 32'h500; mrdy = 1'b1; mdi = 32'h0000_1234;
    tick();
    compared++;
    if ({mreq, ma} !== {1'b1, 32'h500}) begin mismatched++; $display("FAIL rmid_fetch_cmd got mreq=%b ma=%h exp 1/00000500", mreq, ma); end
    tick();
    compared++;
    if ({iack, idata} !== {1'b1, 32'h1234}) begin mismatched++; $display("FAIL rmid_fetch_ack got iack=%b idata=%h exp 1/00001234", iack, idata); end
    $display("reset_mid: refetch ia=%h idata=%h", ia, idata);
    ireq = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_write_wait();
    test_read();
    test_tie();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
